// File: rtl/branch_unit.sv
// Two-stage branch resolve pipeline: S1 captures operands, S2 reports completion/redirect.
// Optional link write-back of pc+1 for jumps is enabled by defining BRANCH_LINK_EN.
`ifndef PC_SIZE
`define PC_SIZE 8
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 16
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif

module branch_unit #(
    parameter int ROB_ADDR_W = 3,
    parameter int D_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ROB_ADDR_W-1:0]          in_rob_addr,
    input  logic                           in_jump,
    input  logic                           in_predict_taken,
    input  logic [`PC_SIZE-1:0]            in_pc,
    input  logic [`PC_SIZE-1:0]            in_predict_target,
    input  logic [$clog2(`NUM_D_REG)-1:0]  in_rt_addr,
    input  logic [$clog2(`NUM_D_REG)-1:0]  in_rw_addr,
    input  logic [$clog2(`NUM_S_REG)-1:0]  in_rs_addr,
    output logic [$clog2(`NUM_D_REG)-1:0]  rt_rd_addr,
    input  logic [D_WIDTH-1:0]             rt_rd_data,
    output logic [$clog2(`NUM_S_REG)-1:0]  rs_rd_addr,
    input  logic                           rs_rd_data,
    input  logic                           flush,
    output logic                           cmp_valid,
    output logic [ROB_ADDR_W-1:0]          cmp_rob_addr,
    output logic                           cmp_mispredict,
    output logic                           cmp_wb_en,
    output logic [$clog2(`NUM_D_REG)-1:0]  cmp_wb_addr,
    output logic [D_WIDTH-1:0]             cmp_wb_data,
    output logic                           redirect_valid,
    output logic [`PC_SIZE-1:0]            redirect_pc,
    input  logic                           redirect_ack
);
    localparam int PCW = `PC_SIZE;
    localparam int DAW = $clog2(`NUM_D_REG);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;

    logic [0:0]            state;
    logic                  s1_valid;
    logic [ROB_ADDR_W-1:0] s1_rob;
    logic                  s1_jump;
    logic                  s1_pt;
    logic [PCW-1:0]        s1_pc;
    logic [PCW-1:0]        s1_ptgt;
    logic [PCW-1:0]        s1_rt;
    logic                  s1_rs;

    logic                  accept;
    logic                  advance;
    logic                  taken;
    logic [PCW-1:0]        pc_inc;
    logic [PCW-1:0]        target;
    logic                  mispredict;

    assign rt_rd_addr = in_rt_addr;
    assign rs_rd_addr = in_rs_addr;

    assign in_ready = ~flush & ((state == IDLE) | ~s1_valid);
    assign accept   = in_valid & in_ready;
    assign advance  = s1_valid & (state == IDLE);

    assign taken      = s1_jump | s1_rs;
    assign pc_inc     = s1_pc + 1'b1;
    assign target     = taken ? s1_rt : pc_inc;
    assign mispredict = (taken != s1_pt) | (taken & (s1_rt != s1_ptgt));

    assign redirect_valid = (state == REDIRECT);

    // A new branch may replace an advancing one in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rob  <= '0;
            s1_jump <= 1'b0;
            s1_pt   <= 1'b0;
            s1_pc   <= '0;
            s1_ptgt <= '0;
            s1_rt   <= '0;
            s1_rs   <= 1'b0;
        end else if (accept) begin
            s1_rob  <= in_rob_addr;
            s1_jump <= in_jump;
            s1_pt   <= in_predict_taken;
            s1_pc   <= in_pc;
            s1_ptgt <= in_predict_target;
            s1_rt   <= rt_rd_data[PCW-1:0];
            s1_rs   <= rs_rd_data;
        end
    end

    // S2 outputs are zero whenever no completion is being reported.
    always_ff @(posedge clk) begin
        if (rst || flush || !advance) begin
            cmp_valid      <= 1'b0;
            cmp_rob_addr   <= '0;
            cmp_mispredict <= 1'b0;
        end else begin
            cmp_valid      <= 1'b1;
            cmp_rob_addr   <= s1_rob;
            cmp_mispredict <= mispredict;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            redirect_pc <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (advance && mispredict) begin
                        state       <= REDIRECT;
                        redirect_pc <= target;
                    end
                end
                REDIRECT: begin
                    if (redirect_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_LINK_EN
    logic [DAW-1:0] s1_rw;

    always_ff @(posedge clk) begin
        if (rst) s1_rw <= '0;
        else if (accept) s1_rw <= in_rw_addr;
    end

    always_ff @(posedge clk) begin
        if (rst || flush || !advance) begin
            cmp_wb_en   <= 1'b0;
            cmp_wb_addr <= '0;
            cmp_wb_data <= '0;
        end else begin
            cmp_wb_en   <= s1_jump;
            cmp_wb_addr <= s1_rw;
            cmp_wb_data <= {{(D_WIDTH-PCW){1'b0}}, pc_inc};
        end
    end

    logic unused_rt_hi;
    assign unused_rt_hi = ^rt_rd_data;
`else
    assign cmp_wb_en   = 1'b0;
    assign cmp_wb_addr = {DAW{1'b0}};
    assign cmp_wb_data = {D_WIDTH{1'b0}};

    logic unused_inputs;
    assign unused_inputs = ^{in_rw_addr, rt_rd_data};
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: vector table plus redirect-hold, flush and throughput sequences.
`ifndef PC_SIZE
`define PC_SIZE 8
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 16
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif

module tb_branch_unit;
    localparam int ROB_ADDR_W = 3;
    localparam int D_WIDTH    = 16;
    localparam int DAW        = $clog2(`NUM_D_REG);
    localparam int SAW        = $clog2(`NUM_S_REG);

    logic                  clk, rst;
    logic                  in_valid, in_ready;
    logic [ROB_ADDR_W-1:0] in_rob_addr;
    logic                  in_jump, in_predict_taken;
    logic [7:0]            in_pc, in_predict_target;
    logic [DAW-1:0]        in_rt_addr, in_rw_addr, rt_rd_addr;
    logic [SAW-1:0]        in_rs_addr, rs_rd_addr;
    logic [D_WIDTH-1:0]    rt_rd_data;
    logic                  rs_rd_data;
    logic                  flush;
    logic                  cmp_valid, cmp_mispredict, cmp_wb_en;
    logic [ROB_ADDR_W-1:0] cmp_rob_addr;
    logic [DAW-1:0]        cmp_wb_addr;
    logic [D_WIDTH-1:0]    cmp_wb_data;
    logic                  redirect_valid, redirect_ack;
    logic [7:0]            redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    branch_unit #(.ROB_ADDR_W(ROB_ADDR_W), .D_WIDTH(D_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rob_addr(in_rob_addr), .in_jump(in_jump),
        .in_predict_taken(in_predict_taken), .in_pc(in_pc),
        .in_predict_target(in_predict_target),
        .in_rt_addr(in_rt_addr), .in_rw_addr(in_rw_addr), .in_rs_addr(in_rs_addr),
        .rt_rd_addr(rt_rd_addr), .rt_rd_data(rt_rd_data),
        .rs_rd_addr(rs_rd_addr), .rs_rd_data(rs_rd_data),
        .flush(flush),
        .cmp_valid(cmp_valid), .cmp_rob_addr(cmp_rob_addr),
        .cmp_mispredict(cmp_mispredict), .cmp_wb_en(cmp_wb_en),
        .cmp_wb_addr(cmp_wb_addr), .cmp_wb_data(cmp_wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ack(redirect_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        jump;
        logic        rs;
        logic        pt;
        logic [7:0]  pc;
        logic [7:0]  ptgt;
        logic [15:0] rt;
        logic [3:0]  rw;
        logic        exp_mp;
        logic [7:0]  exp_tgt;
        logic [15:0] exp_link;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic set_br(input logic [2:0] rob, input logic jump, input logic rs,
                          input logic pt, input logic [7:0] pc, input logic [7:0] ptgt,
                          input logic [15:0] rt, input logic [3:0] rw);
        in_rob_addr       = rob;
        in_jump           = jump;
        rs_rd_data        = rs;
        in_predict_taken  = pt;
        in_pc             = pc;
        in_predict_target = ptgt;
        rt_rd_data        = rt;
        in_rw_addr        = rw;
    endtask

    task automatic check_wb(input string nm, input logic jump, input logic [3:0] rw,
                            input logic [15:0] link);
`ifdef BRANCH_LINK_EN
        chk({nm, " wb_en"},   32'(cmp_wb_en),   32'(jump));
        chk({nm, " wb_addr"}, 32'(cmp_wb_addr), jump ? 32'(rw) : 32'(cmp_wb_addr));
        chk({nm, " wb_data"}, 32'(cmp_wb_data), jump ? 32'(link) : 32'(cmp_wb_data));
`else
        chk({nm, " wb_en"},   32'(cmp_wb_en),   32'(1'b0) & 32'(jump));
        chk({nm, " wb_data"}, 32'(cmp_wb_data), 32'(16'h0) & 32'(link) & 32'(rw));
`endif
    endtask

    task automatic run_vec(input int i);
        int k;
        @(posedge clk); #1;
        set_br(3'(i), vecs[i].jump, vecs[i].rs, vecs[i].pt, vecs[i].pc,
               vecs[i].ptgt, vecs[i].rt, vecs[i].rw);
        in_valid = 1'b1;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        chk($sformatf("v%0d ready", i), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d cmp early", i), 32'(cmp_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d cmp_valid", i), 32'(cmp_valid), 32'd1);
        chk($sformatf("v%0d rob", i), 32'(cmp_rob_addr), 32'(i[2:0]));
        chk($sformatf("v%0d mispredict", i), 32'(cmp_mispredict), 32'(vecs[i].exp_mp));
        chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].exp_mp));
        check_wb($sformatf("v%0d", i), vecs[i].jump, vecs[i].rw, vecs[i].exp_link);
        if (vecs[i].exp_mp) begin
            chk($sformatf("v%0d redirect_pc", i), 32'(redirect_pc), 32'(vecs[i].exp_tgt));
            redirect_ack = 1'b1;
            @(posedge clk); #1;
            redirect_ack = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("v%0d cmp pulse", i), 32'(cmp_valid), 32'd0);
        chk($sformatf("v%0d redirect clear", i), 32'(redirect_valid), 32'd0);
    endtask

    initial begin
        //               jump rs pt  pc     ptgt   rt        rw    mp  tgt    link
        vecs[0] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'h40, 16'h0040, 4'd0, 1'b0, 8'h40, 16'h0011};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h40, 16'h0040, 4'd0, 1'b1, 8'h00, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h20, 8'h80, 16'h0080, 4'd3, 1'b0, 8'h80, 16'h0021};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h30, 8'h00, 16'h0077, 4'd0, 1'b0, 8'h31, 16'h0031};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h40, 8'h50, 16'h0055, 4'd0, 1'b1, 8'h55, 16'h0041};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h50, 8'h60, 16'h0060, 4'd0, 1'b1, 8'h60, 16'h0051};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h7F, 8'h90, 16'h1290, 4'd5, 1'b0, 8'h90, 16'h0080};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 16'h0033, 4'd7, 1'b1, 8'h33, 16'h0002};

        rst = 1'b1; flush = 1'b0; redirect_ack = 1'b0; in_valid = 1'b0;
        in_rt_addr = 4'd5; in_rs_addr = 3'd6;
        set_br(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0, 4'd0);

        // reset
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset cmp_valid", 32'(cmp_valid), 32'd0);
        chk("reset redirect_valid", 32'(redirect_valid), 32'd0);
        chk("reset redirect_pc", 32'(redirect_pc), 32'd0);
        chk("reset cmp_mispredict", 32'(cmp_mispredict), 32'd0);
        chk("rt_rd_addr passthrough", 32'(rt_rd_addr), 32'd5);
        chk("rs_rd_addr passthrough", 32'(rs_rd_addr), 32'd6);

        // ack while idle must be ignored
        redirect_ack = 1'b1;
        @(posedge clk); #1;
        redirect_ack = 1'b0;
        @(negedge clk);
        chk("idle ack ignored", 32'(redirect_valid), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // mispredict held for 5 cycles with a second branch parked in S1
        @(posedge clk); #1;
        set_br(3'd1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h40, 16'h0040, 4'd0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("hold b1 ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        set_br(3'd2, 1'b0, 1'b1, 1'b1, 8'h10, 8'h40, 16'h0040, 4'd0);
        @(negedge clk);
        chk("hold b2 ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold redirect c%0d", i), 32'(redirect_valid), 32'd1);
            chk($sformatf("hold cmp c%0d", i), 32'(cmp_valid), 32'(i == 0));
            chk($sformatf("hold stall c%0d", i), 32'(in_ready), 32'd0);
            if (i == 0) begin
                chk("hold mispredict", 32'(cmp_mispredict), 32'd1);
                chk("hold redirect_pc wrap", 32'(redirect_pc), 32'h00);
            end
            if (i == 4) redirect_ack = 1'b1;
        end
        @(posedge clk); #1;
        redirect_ack = 1'b0;
        @(negedge clk);
        chk("post-ack redirect", 32'(redirect_valid), 32'd0);
        chk("post-ack cmp", 32'(cmp_valid), 32'd0);
        @(negedge clk);
        chk("b2 cmp_valid", 32'(cmp_valid), 32'd1);
        chk("b2 rob", 32'(cmp_rob_addr), 32'd2);
        chk("b2 mispredict", 32'(cmp_mispredict), 32'd0);
        chk("b2 no redirect", 32'(redirect_valid), 32'd0);

        // flush coincident with ack squashes the parked branch
        @(posedge clk); #1;
        set_br(3'd3, 1'b0, 1'b0, 1'b1, 8'h22, 8'h40, 16'h0040, 4'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_br(3'd4, 1'b0, 1'b0, 1'b0, 8'h23, 8'h00, 16'h0000, 4'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("flush redirect c%0d", i), 32'(redirect_valid), 32'd1);
            if (i == 1) begin
                redirect_ack = 1'b1;
                flush = 1'b1;
                in_valid = 1'b1;
                #1;
                chk("flush blocks accept", 32'(in_ready), 32'd0);
            end
        end
        @(posedge clk); #1;
        redirect_ack = 1'b0; flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("flush no cmp c%0d", i), 32'(cmp_valid), 32'd0);
            chk($sformatf("flush no redirect c%0d", i), 32'(redirect_valid), 32'd0);
            chk($sformatf("flush ready c%0d", i), 32'(in_ready), 32'd1);
        end

        // throughput: 8 back-to-back correctly predicted branches
        @(posedge clk); #1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                set_br(3'(c), 1'b0, 1'b0, 1'b0, 8'(8'h60 + c), 8'h00, 16'h0000, 4'd0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 8) chk($sformatf("tp ready c%0d", c), 32'(in_ready), 32'd1);
            chk($sformatf("tp cmp c%0d", c), 32'(cmp_valid), 32'(c >= 2 && c < 10));
            if (c >= 2 && c < 10) begin
                chk($sformatf("tp rob c%0d", c), 32'(cmp_rob_addr), 32'(c - 2));
                chk($sformatf("tp mp c%0d", c), 32'(cmp_mispredict), 32'd0);
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
